// File: rtl/ib_mul_8x8_s2_l0_core_if.sv
// Operand/product bundle for the ib_mul 8x8 multiplier: operands with a valid
// qualifier in, combinational and registered products out.
interface ib_mul_8x8_s2_l0_core_if;
    logic [7:0]  i_a;
    logic [7:0]  i_b;
    logic        i_vld;
    logic [15:0] o_c;
    logic [15:0] o_c_q;
    logic        o_vld_q;

    // Handshake: i_vld is a one-way qualifier with no ready; every cycle with
    // i_vld high is captured, and o_vld_q marks the capture one edge later.
    modport master (
        output i_a, i_b, i_vld,
        input  o_c, o_c_q, o_vld_q
    );

    modport slave (
        input  i_a, i_b, i_vld,
        output o_c, o_c_q, o_vld_q
    );
endinterface

// File: rtl/ib_mul_8x8_s2_l0_core.sv
// Unsigned 8x8 multiplier built from four 2-bit slices of the multiplier,
// with a zero-latency product and a registered, valid-qualified copy.
module ib_mul_8x8_s2_l0_core (
    input  logic                         i_clk,
    input  logic                         i_rst,
    ib_mul_8x8_s2_l0_core_if.slave       bus
);
    logic [9:0]  a_x1;
    logic [9:0]  a_x2;
    logic [9:0]  a_x3;
    logic [9:0]  pp [4];
    logic [15:0] sum_lo;
    logic [15:0] sum_hi;
    logic [15:0] prod;
    logic [15:0] c_q;
    logic        vld_q;

    assign a_x1 = {2'b00, bus.i_a};
    assign a_x2 = {1'b0, bus.i_a, 1'b0};
    assign a_x3 = a_x1 + a_x2;

    // Each slice value selects 0, a, 2a or 3a; 3a peaks at 765 and fits 10 bits.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pp[k] = '0;
            case (bus.i_b[2*k +: 2])
                2'd0: pp[k] = '0;
                2'd1: pp[k] = a_x1;
                2'd2: pp[k] = a_x2;
                2'd3: pp[k] = a_x3;
                default: pp[k] = '0;
            endcase
        end
    end

    assign sum_lo = {6'b0, pp[0]} + {4'b0, pp[1], 2'b00};
    assign sum_hi = {6'b0, pp[2]} + {4'b0, pp[3], 2'b00};
    assign prod   = sum_lo + (sum_hi << 4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            c_q   <= 16'h0000;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.i_vld;
            if (bus.i_vld) begin
                c_q <= prod;
            end
        end
    end

    assign bus.o_c     = prod;
    assign bus.o_c_q   = c_q;
    assign bus.o_vld_q = vld_q;
endmodule

// File: tb/tb_ib_mul_8x8_s2_l0_core.sv
// Self-checking bench for ib_mul_8x8_s2_l0_core: vector table, exhaustive
// sweep, hand-written registered-path sequences and a random clocked stream.
module tb_ib_mul_8x8_s2_l0_core;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ib_mul_8x8_s2_l0_core_if bus ();

    ib_mul_8x8_s2_l0_core dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%04h), expected %0d (0x%04h)", name, act, act, exp, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic vld);
        bus.i_a   = a;
        bus.i_b   = b;
        bus.i_vld = vld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] model_c;
        logic [15:0] exp_c;
        logic        model_v;
        logic        sweep_bad;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rv;
        logic        rr;

        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(8'd0, 8'd0, 1'b0);

        vecs[0] = '{8'd0,   8'd0,   16'd0};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd1,   8'd200, 16'd200};
        vecs[3] = '{8'd128, 8'd2,   16'd256};
        vecs[4] = '{8'd170, 8'd85,  16'd14450};
        vecs[5] = '{8'd3,   8'd3,   16'd9};
        vecs[6] = '{8'd255, 8'd3,   16'd765};
        vecs[7] = '{8'd255, 8'd12,  16'd3060};
        vecs[8] = '{8'd255, 8'd48,  16'd12240};
        vecs[9] = '{8'd255, 8'd192, 16'd48960};

        // Reset held two cycles; o_c remains live during reset
        step();
        step();
        check("reset_c_q", bus.o_c_q, 16'd0);
        check("reset_vld_q", {15'd0, bus.o_vld_q}, 16'd0);
        drive(8'd7, 8'd9, 1'b0);
        #1;
        check("comb_in_reset", bus.o_c, 16'd63);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, 1'b0);
            #1;
            check($sformatf("table_%0dx%0d", vecs[i].a, vecs[i].b), bus.o_c, vecs[i].c);
        end

        // Exhaustive sweep, abandoned at the first mismatch
        sweep_bad = 1'b0;
        for (int a = 0; a < 256 && !sweep_bad; a++) begin
            for (int b = 0; b < 256 && !sweep_bad; b++) begin
                drive(8'(a), 8'(b), 1'b0);
                #1;
                exp_c = 16'(a * b);
                if (bus.o_c !== exp_c) begin
                    sweep_bad = 1'b1;
                    check($sformatf("sweep_%0dx%0d", a, b), bus.o_c, exp_c);
                end else begin
                    n_vec++;
                end
            end
        end

        // Registered path: capture, then hold with i_vld low
        step();
        drive(8'd13, 8'd17, 1'b1);
        step();
        check("reg_capture_c_q", bus.o_c_q, 16'd221);
        check("reg_capture_vld", {15'd0, bus.o_vld_q}, 16'd1);
        drive(8'd2, 8'd2, 1'b0);
        step();
        check("reg_hold_c_q", bus.o_c_q, 16'd221);
        check("reg_hold_vld", {15'd0, bus.o_vld_q}, 16'd0);
        check("reg_hold_comb", bus.o_c, 16'd4);

        // Reset wins over a valid operand on the same edge
        drive(8'd200, 8'd200, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_comb_before", bus.o_c, 16'd40000);
        step();
        check("midrst_c_q", bus.o_c_q, 16'd0);
        check("midrst_vld", {15'd0, bus.o_vld_q}, 16'd0);
        check("midrst_comb_after", bus.o_c, 16'd40000);
        rst = 1'b0;

        // Back-to-back captures
        drive(8'd1, 8'd1, 1'b1);
        step();
        check("b2b_0", bus.o_c_q, 16'd1);
        drive(8'd2, 8'd3, 1'b1);
        step();
        check("b2b_1", bus.o_c_q, 16'd6);
        drive(8'd255, 8'd1, 1'b1);
        step();
        check("b2b_2", bus.o_c_q, 16'd255);
        check("b2b_vld", {15'd0, bus.o_vld_q}, 16'd1);

        // Random clocked stream against an arithmetic model of the registers
        model_c = 16'd255;
        model_v = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 19) == 0);
            drive(ra, rb, rv);
            rst = rr;
            #1;
            check("rand_comb", bus.o_c, 16'(int'(ra) * int'(rb)));
            if (rr) begin
                model_c = 16'd0;
                model_v = 1'b0;
            end else begin
                model_v = rv;
                if (rv) model_c = 16'(int'(ra) * int'(rb));
            end
            exp_q.push_back(model_c);
            step();
            check("rand_c_q", bus.o_c_q, exp_q.pop_front());
            check("rand_vld", {15'd0, bus.o_vld_q}, {15'd0, model_v});
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
